ef_dac_seq: RTL and testbench

EF_DAC_SEQ -- requirements
Module: ef_dac_seq

---
 rtl/ef_dac_seq_pkg.sv | 20 ++
 rtl/ef_dac_seq_fifo.sv | 57 +++++
 rtl/ef_dac_seq.sv | 129 ++++++++++++
 tb/tb_ef_dac_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_dac_seq_pkg.sv
// ef_dac_seq_pkg: shared types and width constants for the DAC sequencer.
// Holds the FSM state enum, timer width and width helper functions.
package ef_dac_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TMR_W = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ef_dac_seq_fifo.sv
// ef_dac_seq_fifo: sample FIFO with occupancy count and synchronous flush.
// Ports: clk, rst_n, flush, push/wdata, pop/rdata, level, full, empty.
module ef_dac_seq_fifo
    import ef_dac_seq_pkg::*;
#(
    parameter int DW    = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic [ptr_w(DEPTH):0]      level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ef_dac_seq.sv
// ef_dac_seq: timed DAC sample sequencer, round-robin over NCH channels.
// Ports: clk, rst_n, en, flush, period, wr_valid/wr_ready/wr_data, level,
//   dac_en, dac_data, dac_ch, dac_upd, underrun.
// Option EF_DAC_SEQ_STICKY_UR_EN adds ur_clr input and sticky ur_flag output.
module ef_dac_seq
    import ef_dac_seq_pkg::*;
#(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    parameter int NCH   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic [TMR_W-1:0]         period,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DW-1:0]            wr_data,
    output logic [ptr_w(DEPTH):0]    level,
    output logic                     dac_en,
    output logic [DW-1:0]            dac_data,
    output logic [ch_w(NCH)-1:0]     dac_ch,
    output logic                     dac_upd,
    output logic                     underrun
`ifdef EF_DAC_SEQ_STICKY_UR_EN
    ,
    input  logic                     ur_clr,
    output logic                     ur_flag
`endif
);

    localparam int CW = ch_w(NCH);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CW-1:0]    ch;
    logic [CW-1:0]    ch_nxt;
    logic [DW-1:0]    rdata;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             tick;
    logic             ur_evt;

    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    // Tick is gated by en so the disabling cycle never pops.
    assign tick     = (state == RUN) && en && (timer == '0);
    // Emptiness is the pre-push view: a same-cycle push cannot be popped.
    assign pop      = tick && !empty && !flush;
    assign ur_evt   = tick && empty;
    assign ch_nxt   = (ch == CW'(NCH - 1)) ? '0 : ch + CW'(1);

    ef_dac_seq_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            ch       <= '0;
            dac_en   <= 1'b0;
            dac_data <= '0;
            dac_ch   <= '0;
            dac_upd  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            dac_en   <= en;
            dac_upd  <= 1'b0;
            underrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        timer <= period;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        timer <= '0;
                        ch    <= '0;
                    end else if (timer == '0) begin
                        timer <= period;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (pop) begin
                dac_data <= rdata;
                dac_ch   <= ch;
                dac_upd  <= 1'b1;
                ch       <= ch_nxt;
            end
            if (ur_evt) underrun <= 1'b1;
        end
    end

`ifdef EF_DAC_SEQ_STICKY_UR_EN
    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ur_flag <= 1'b0;
        end else if (ur_evt) begin
            ur_flag <= 1'b1;
        end else if (ur_clr) begin
            ur_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ef_dac_seq.sv
// tb_ef_dac_seq: scoreboard bench for ef_dac_seq (DW=10, DEPTH=4, NCH=3).
// Expected dac_upd/underrun events are queued; a monitor pops and compares.
module tb_ef_dac_seq;

    typedef struct packed {
        logic       ur;
        logic [9:0] d;
        logic [1:0] ch;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [15:0] period;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_data;
    logic [2:0]  level;
    logic        dac_en;
    logic [9:0]  dac_data;
    logic [1:0]  dac_ch;
    logic        dac_upd;
    logic        underrun;
`ifdef EF_DAC_SEQ_STICKY_UR_EN
    logic        ur_clr;
    logic        ur_flag;
`endif

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  scen   = 0;
    int  exp_gap = 0;

    ef_dac_seq #(
        .DW    (10),
        .DEPTH (4),
        .NCH   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .period   (period),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .level    (level),
        .dac_en   (dac_en),
        .dac_data (dac_data),
        .dac_ch   (dac_ch),
        .dac_upd  (dac_upd),
        .underrun (underrun)
`ifdef EF_DAC_SEQ_STICKY_UR_EN
        ,
        .ur_clr   (ur_clr),
        .ur_flag  (ur_flag)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_upd(input logic [9:0] d, input logic [1:0] ch);
        exp_q.push_back({1'b0, d, ch});
    endtask

    task automatic exp_ur();
        exp_q.push_back({1'b1, 10'h000, 2'd0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keeps pushing base+k until n samples are accepted (bounded).
    task automatic push_stream(input logic [9:0] base, input int n);
        int   k;
        int   guard;
        logic acc;
        k = 0;
        guard = 0;
        while (k < n && guard < 50) begin
            wr_valid = 1'b1;
            wr_data  = base + 10'(k);
            acc      = wr_ready;
            step();
            if (acc) k++;
            guard++;
        end
        wr_valid = 1'b0;
        chk("push_stream_done", k, n);
    endtask

    // Monitor: compares every DUT event against the queue head.
    initial begin
        ev_t e;
        int  mon_scen;
        int  last;
        mon_scen = -1;
        last     = -1;
        forever begin
            @(negedge clk);
            if (rst_n && (dac_upd || underrun)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, dac_upd, underrun}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_is_underrun", int'(underrun), int'(e.ur));
                    chk("ev_is_upd", int'(dac_upd), int'(!e.ur));
                    if (!e.ur) begin
                        chk("dac_data", int'(dac_data), int'(e.d));
                        chk("dac_ch", int'(dac_ch), int'(e.ch));
                    end
                end
                if (dac_upd) begin
                    if (mon_scen != scen) begin
                        mon_scen = scen;
                        last     = -1;
                    end
                    if (last >= 0 && exp_gap > 0)
                        chk("upd_gap", cyc - last, exp_gap);
                    last = cyc;
                end
            end
        end
    end

    initial begin
        int accepted;
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        period   = 16'd0;
        wr_valid = 1'b0;
        wr_data  = 10'h000;
`ifdef EF_DAC_SEQ_STICKY_UR_EN
        ur_clr   = 1'b0;
`endif
        step();
        step();
        chk("rst_dac_en", int'(dac_en), 0);
        chk("rst_dac_data", int'(dac_data), 0);
        chk("rst_dac_ch", int'(dac_ch), 0);
        chk("rst_dac_upd", int'(dac_upd), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        rst_n = 1'b1;
        step();

        // Two samples, period 3: updates 4 cycles apart, then underrun.
        scen    = 1;
        exp_gap = 4;
        period  = 16'd3;
        push_stream(10'h155, 1);
        push_stream(10'h2AA, 1);
        chk("s1_level", int'(level), 2);
        exp_upd(10'h155, 2'd0);
        exp_upd(10'h2AA, 2'd1);
        exp_ur();
        en = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        chk("s1_underrun", int'(underrun), 1);
        chk("s1_hold_data", int'(dac_data), 'h2AA);
        chk("s1_dac_en", int'(dac_en), 1);
        en = 1'b0;
        step();
        step();
        chk("s1_level_end", int'(level), 0);
        chk("s1_dac_en_off", int'(dac_en), 0);

        // Push coinciding with tick on empty FIFO.
        scen    = 2;
        exp_gap = 0;
        period  = 16'd0;
        en      = 1'b1;
        step();
        wr_valid = 1'b1;
        wr_data  = 10'h3C3;
        exp_ur();
        step();
        wr_valid = 1'b0;
        en       = 1'b0;
        chk("s2_underrun", int'(underrun), 1);
        chk("s2_level", int'(level), 1);
        chk("s2_no_upd", int'(dac_upd), 0);
        step();
        step();
        chk("s2_level_kept", int'(level), 1);

        // Flush at level 3 with a push in the same cycle.
        push_stream(10'h011, 2);
        chk("s3_level", int'(level), 3);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 10'h3FF;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("s3_flush_level", int'(level), 0);
        chk("s3_wr_ready", int'(wr_ready), 1);

        // Five pushes into a depth-4 FIFO while disabled.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 10'h200 + 10'(i);
            if (wr_ready) accepted++;
            step();
        end
        wr_valid = 1'b0;
        chk("s4_accepted", accepted, 4);
        chk("s4_level", int'(level), 4);
        chk("s4_wr_ready", int'(wr_ready), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s4_flush_level", int'(level), 0);

        // Period 0, 6 samples: channels 0,1,2,0,1,2 on consecutive cycles.
        scen    = 3;
        exp_gap = 1;
        period  = 16'd0;
        for (int k = 0; k < 6; k++)
            exp_upd(10'h101 + 10'(k), 2'(k % 3));
        push_stream(10'h101, 4);
        chk("s5_full_level", int'(level), 4);
        fork
            push_stream(10'h105, 2);
            begin
                en = 1'b1;
                repeat (7) @(posedge clk);
                #1;
                en = 1'b0;
            end
        join
        step();
        chk("s5_level_end", int'(level), 0);
        chk("s5_last_ch", int'(dac_ch), 2);
        chk("s5_last_data", int'(dac_data), 'h106);

        // Asynchronous reset while dac_upd is high.
        scen    = 4;
        exp_gap = 0;
        period  = 16'd0;
        push_stream(10'h0A5, 2);
        exp_upd(10'h0A5, 2'd0);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #6;
        rst_n = 1'b0;
        #1;
        chk("s6_dac_en", int'(dac_en), 0);
        chk("s6_dac_data", int'(dac_data), 0);
        chk("s6_dac_ch", int'(dac_ch), 0);
        chk("s6_dac_upd", int'(dac_upd), 0);
        chk("s6_underrun", int'(underrun), 0);
        chk("s6_level", int'(level), 0);
        chk("s6_wr_ready", int'(wr_ready), 1);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("s6_level_after", int'(level), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
